vga_rx_monitor: RTL and testbench

VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

---
 rtl/vga_rx_if.sv | 13 +
 rtl/vga_rx_monitor.sv | 178 +++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_rx_if.sv
// VGA receive-side signal bundle: pixel strobe, active-low syncs and colour.
// The source drives the master modport, the monitor samples through slave.
interface vga_rx_if #(
  parameter int CD = 12
);
  logic          pix_en;
  logic          hsync;
  logic          vsync;
  logic [CD-1:0] rgb;

  modport master (output pix_en, hsync, vsync, rgb);
  modport slave  (input  pix_en, hsync, vsync, rgb);
endinterface

// File: rtl/vga_rx_monitor.sv
// VGA timing monitor: measures line/frame geometry, checksums the active
// area, captures one pixel and tracks lock against the expected timing.
//
// state  | meaning
// SEARCH | no frame reference yet, waiting for the first vsync fall
// TRACK  | frame-aligned, counting consecutive clean frames
// LOCKED | two or more consecutive clean frames seen
module vga_rx_monitor #(
  parameter int CD       = 12,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic          clk,
  input  logic          rst_n,
  vga_rx_if.slave       vga,
  input  logic [9:0]    sample_x,
  input  logic [9:0]    sample_y,
  output logic          locked,
  output logic          frame_done,
  output logic          frame_ok,
  output logic [10:0]   line_len,
  output logic [10:0]   frame_lines,
  output logic [23:0]   checksum,
  output logic [CD-1:0] sample_rgb,
  output logic [7:0]    err_cnt
);

  localparam logic [10:0] H_A0  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_A1  = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_A0  = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_A1  = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [10:0] H_TOT = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT = 11'(V_TOTAL);
  localparam logic [10:0] CNT_MAX = 11'd2047;
  localparam int TIMEOUT = 2 * V_TOTAL * H_TOTAL;
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t         state, state_nx;
  logic [1:0]     good_cnt, good_nx;
  logic           err_inc;
  logic           emit;

  logic           hs_prev, vs_prev;
  logic [10:0]    hcnt, vcnt;
  logic [10:0]    h_inc, v_inc, h_pos, v_pos;
  logic [10:0]    ax, ay;
  logic           tick, hf, vf;
  logic           line_bad, bad, bad_next, frame_good;
  logic           active, hit, timeout;
  logic [23:0]    acc;
  logic [23:0]    rgb_ext;
  logic [TO_W-1:0] tmr;

  assign tick = vga.pix_en;
  assign hf   = tick & hs_prev & ~vga.hsync;
  assign vf   = tick & vs_prev & ~vga.vsync;

  // h_pos/v_pos are the coordinates of the current tick; the hf tick is column 0
  assign h_inc = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + 11'd1;
  assign v_inc = (vcnt == CNT_MAX) ? CNT_MAX : vcnt + 11'd1;
  assign h_pos = hf ? 11'd0 : h_inc;
  assign v_pos = vf ? 11'd0 : (hf ? v_inc : vcnt);

  assign line_bad   = hf && (h_inc != H_TOT);
  assign bad_next   = bad | line_bad | (vf & ~hf);
  assign frame_good = !bad_next && (v_inc == V_TOT);

  assign active  = tick && (h_pos >= H_A0) && (h_pos < H_A1)
                        && (v_pos >= V_A0) && (v_pos < V_A1);
  assign ax      = h_pos - H_A0;
  assign ay      = v_pos - V_A0;
  assign hit     = active && (ax == {1'b0, sample_x}) && (ay == {1'b0, sample_y});
  assign rgb_ext = 24'(vga.rgb);
  assign timeout = tick && !vf && (tmr == TO_W'(1));

  assign locked  = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      good_cnt <= 2'd0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_nx;
    end
  end

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    err_inc  = 1'b0;
    emit     = 1'b0;
    if (vf) begin
      case (state)
        SEARCH: begin
          state_nx = TRACK;
          good_nx  = 2'd0;
        end
        TRACK: begin
          emit = 1'b1;
          if (frame_good) begin
            good_nx = good_cnt + 2'd1;
            if (good_cnt == 2'd1) state_nx = LOCKED;
          end else begin
            good_nx = 2'd0;
          end
        end
        LOCKED: begin
          emit = 1'b1;
          if (!frame_good) begin
            state_nx = TRACK;
            good_nx  = 2'd0;
            err_inc  = 1'b1;
          end
        end
        default: state_nx = SEARCH;
      endcase
    end else if (timeout) begin
      state_nx = SEARCH;
      good_nx  = 2'd0;
      err_inc  = (state == LOCKED);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev     <= 1'b0;
      vs_prev     <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      bad         <= 1'b0;
      acc         <= '0;
      tmr         <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      checksum    <= '0;
      frame_ok    <= 1'b0;
      frame_done  <= 1'b0;
      sample_rgb  <= '0;
      err_cnt     <= '0;
    end else begin
      frame_done <= emit;
      if (tick) begin
        hs_prev <= vga.hsync;
        vs_prev <= vga.vsync;
        hcnt    <= h_pos;
        vcnt    <= v_pos;
        if (hf) line_len <= h_inc;
        // the vf tick's own pixel opens the new frame's sum
        if (vf) begin
          frame_lines <= v_inc;
          acc         <= active ? rgb_ext : 24'd0;
          bad         <= 1'b0;
          tmr         <= TO_W'(TIMEOUT);
        end else begin
          acc <= active ? acc + rgb_ext : acc;
          bad <= bad_next;
          if (tmr != '0) tmr <= tmr - TO_W'(1);
        end
        if (hit) sample_rgb <= vga.rgb;
      end
      if (emit) begin
        checksum <= acc;
        frame_ok <= frame_good;
      end
      if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Randomized bench for vga_rx_monitor on a scaled-down raster, checked every
// clock against a coordinate-level model, plus hand-computed frame results.
module tb_vga_rx_monitor;

  localparam int CD  = 12;
  localparam int HS  = 4;
  localparam int HB  = 3;
  localparam int HA  = 10;
  localparam int HT  = 20;
  localparam int VS  = 2;
  localparam int VB  = 2;
  localparam int VA  = 6;
  localparam int VT  = 12;
  localparam int TMO = 2 * VT * HT;
  localparam int HA0 = HS + HB;
  localparam int VA0 = VS + VB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    sample_x = '0;
  logic [9:0]    sample_y = '0;
  logic          locked, frame_done, frame_ok;
  logic [10:0]   line_len, frame_lines;
  logic [23:0]   checksum;
  logic [CD-1:0] sample_rgb;
  logic [7:0]    err_cnt;

  int tests = 0;
  int fails = 0;

  vga_rx_if #(.CD(CD)) vga_bus ();

  vga_rx_monitor #(
    .CD(CD), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga(vga_bus.slave),
    .sample_x(sample_x), .sample_y(sample_y),
    .locked(locked), .frame_done(frame_done), .frame_ok(frame_ok),
    .line_len(line_len), .frame_lines(frame_lines), .checksum(checksum),
    .sample_rgb(sample_rgb), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_hpos, m_vpos, m_hsp, m_vsp, m_acc, m_bad, m_synced, m_good;
  int m_line_len, m_frame_lines, m_checksum, m_frame_ok, m_sample, m_err;
  int m_since_vf, m_frame_done;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    m_hpos = 0; m_vpos = 0; m_hsp = 0; m_vsp = 0; m_acc = 0; m_bad = 0;
    m_synced = 0; m_good = 0; m_line_len = 0; m_frame_lines = 0;
    m_checksum = 0; m_frame_ok = 0; m_sample = 0; m_err = 0;
    m_since_vf = 0; m_frame_done = 0;
  endtask

  task automatic model_step();
    int hf, vf, nh, nv, fl, ok, act;
    m_frame_done = 0;
    if (!rst_n) begin
      model_reset();
    end else if (vga_bus.pix_en) begin
      hf = (m_hsp == 1 && vga_bus.hsync == 1'b0) ? 1 : 0;
      vf = (m_vsp == 1 && vga_bus.vsync == 1'b0) ? 1 : 0;
      nh = hf ? 0 : sat(m_hpos + 1, 2047);
      fl = sat(m_vpos + 1, 2047);
      nv = vf ? 0 : (hf ? fl : m_vpos);
      if (hf) begin
        m_line_len = sat(m_hpos + 1, 2047);
        if (m_line_len != HT) m_bad = 1;
      end
      if (vf && !hf) m_bad = 1;
      act = (nh >= HA0 && nh < HA0 + HA && nv >= VA0 && nv < VA0 + VA) ? 1 : 0;
      if (vf) begin
        m_frame_lines = fl;
        if (m_synced) begin
          m_frame_done = 1;
          m_checksum = m_acc;
          ok = (!m_bad && fl == VT) ? 1 : 0;
          m_frame_ok = ok;
          if (ok) m_good = sat(m_good + 1, 2);
          else begin
            if (m_good >= 2) m_err = sat(m_err + 1, 255);
            m_good = 0;
          end
        end else begin
          m_synced = 1;
          m_good = 0;
        end
        m_acc = 0;
        m_bad = 0;
        m_since_vf = 0;
      end else begin
        m_since_vf++;
        if (m_synced && m_since_vf == TMO) begin
          if (m_good >= 2) m_err = sat(m_err + 1, 255);
          m_synced = 0;
          m_good = 0;
        end
      end
      if (act) begin
        m_acc = (m_acc + int'(vga_bus.rgb)) % (1 << 24);
        if (nh - HA0 == int'(sample_x) && nv - VA0 == int'(sample_y))
          m_sample = int'(vga_bus.rgb);
      end
      m_hpos = nh;
      m_vpos = nv;
      m_hsp = int'(vga_bus.hsync);
      m_vsp = int'(vga_bus.vsync);
    end
  endtask

  initial model_reset();

  always begin
    @(posedge clk);
    #1;
    model_step();
    check("locked",      int'(locked),      (m_synced && m_good >= 2) ? 1 : 0);
    check("frame_done",  int'(frame_done),  m_frame_done);
    check("frame_ok",    int'(frame_ok),    m_frame_ok);
    check("line_len",    int'(line_len),    m_line_len);
    check("frame_lines", int'(frame_lines), m_frame_lines);
    check("checksum",    int'(checksum),    m_checksum);
    check("sample_rgb",  int'(sample_rgb),  m_sample);
    check("err_cnt",     int'(err_cnt),     m_err);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic hs, input logic vs, input logic [CD-1:0] px);
    if ($urandom_range(3) == 0) begin
      @(negedge clk);
      vga_bus.pix_en = 1'b0;
      vga_bus.hsync  = 1'($urandom);
      vga_bus.vsync  = 1'($urandom);
      vga_bus.rgb    = CD'($urandom);
    end
    @(negedge clk);
    vga_bus.pix_en = 1'b1;
    vga_bus.hsync  = hs;
    vga_bus.vsync  = vs;
    vga_bus.rgb    = px;
  endtask

  // mode 0 random colour, 1 ones in active area, 2 all-ones active, 3 0xABC at last pixel only
  task automatic run_frame(input int first, input int stop, input int long_line,
                           input bit vs_en, input int mode);
    for (int l = first; l < stop; l++) begin
      int len;
      len = (l == long_line) ? HT + 1 : HT;
      for (int c = 0; c < len; c++) begin
        logic [CD-1:0] px;
        bit act;
        act = (c >= HA0 && c < HA0 + HA && l >= VA0 && l < VA0 + VA);
        case (mode)
          1:       px = act ? CD'(1) : '0;
          2:       px = act ? '1 : '0;
          3:       px = (act && c == HA0 + HA - 1 && l == VA0 + VA - 1) ? 12'hABC : '0;
          default: px = CD'($urandom);
        endcase
        tick(c >= HS, vs_en ? (l >= VS) : 1'b1, px);
      end
    end
  endtask

  task automatic frame(input int mode);
    run_frame(0, VT, -1, 1'b1, mode);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"},   int'(locked), 0);
    check({tag, "_done"},     int'(frame_done), 0);
    check({tag, "_ok"},       int'(frame_ok), 0);
    check({tag, "_line_len"}, int'(line_len), 0);
    check({tag, "_lines"},    int'(frame_lines), 0);
    check({tag, "_cksum"},    int'(checksum), 0);
    check({tag, "_sample"},   int'(sample_rgb), 0);
    check({tag, "_err"},      int'(err_cnt), 0);
  endtask

  initial begin
    vga_bus.pix_en = 1'b0;
    vga_bus.hsync  = 1'b1;
    vga_bus.vsync  = 1'b1;
    vga_bus.rgb    = '0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;

    // lock-in from reset: partial, then vf on frames B, C, D
    frame(1); frame(1); frame(1);
    settle();
    check("lock_before_3rd_vf", int'(locked), 0);
    frame(1);
    settle();
    check("lock_after_3rd_vf", int'(locked), 1);
    check("cksum_ones", int'(checksum), HA * VA);
    check("ok_clean", int'(frame_ok), 1);
    check("line_len_std", int'(line_len), HT);
    check("lines_std", int'(frame_lines), VT);

    frame(2); frame(0);
    settle();
    check("cksum_fff", int'(checksum), 60 * 4095);

    // one overlong line while locked
    run_frame(0, VT, 3, 1'b1, 0);
    frame(0);
    settle();
    check("long_ok", int'(frame_ok), 0);
    check("long_locked", int'(locked), 0);
    check("long_err", int'(err_cnt), 1);
    frame(0); frame(0);
    settle();
    check("relock", int'(locked), 1);

    // sample the bottom-right active pixel
    sample_x = 10'(HA - 1);
    sample_y = 10'(VA - 1);
    frame(3);
    settle();
    check("sample_corner", int'(sample_rgb), 12'hABC);

    // vsync stuck high for two frames
    run_frame(0, VT, -1, 1'b0, 0);
    run_frame(0, VT, -1, 1'b0, 0);
    settle();
    check("timeout_locked", int'(locked), 0);
    check("timeout_err", int'(err_cnt), 2);

    // out-of-range sample coordinate leaves sample_rgb alone
    sample_x = 10'(HA);
    sample_y = 10'd0;
    frame(1); frame(1); frame(1);
    settle();
    check("relock_after_to", int'(locked), 1);
    check("sample_kept", int'(sample_rgb), 12'hABC);
    check("cksum_ones2", int'(checksum), HA * VA);

    // randomized geometry and sample points
    for (int f = 0; f < 8; f++) begin
      sample_x = 10'($urandom_range(HA));
      sample_y = 10'($urandom_range(VA));
      run_frame(0, VT, ($urandom_range(3) == 0) ? int'($urandom_range(VT - 1)) : -1,
                ($urandom_range(5) != 0), 0);
    end

    // reset mid-frame, then one partial and two clean frames
    run_frame(0, 5, -1, 1'b1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(5, VT, -1, 1'b1, 0);
    frame(0); frame(0);
    settle();
    check("midrst_not_yet", int'(locked), 0);
    frame(0);
    settle();
    check("midrst_lock", int'(locked), 1);
    check("midrst_err", int'(err_cnt), 0);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
